pv1000_ram_uploader: RTL
========================

Name: pv1000_ram_uploader

Overview:
- Reads the 64 KiB system dpram and returns its contents to the HPS through the hps_io ioctl upload handshake. This is the reverse of the cartridge/RAM download path.
- Used for RAM dumps and save-state style snapshots.
- Sits in clk_sys beside the dpram and drives the dpram's second read port (address_b/q_b, time-shared with the VDP via an external mux gated by busy).

Parameters:
- ADDR_W, 16, dpram address width.
- SIZE, 65536, number of bytes served; reads at offsets >= SIZE return 8'hFF.
- BASE, 0, dpram address that corresponds to upload offset 0 (wraps modulo 2^ADDR_W).
- TIMEOUT, 16777215, clk cycles to wait for ioctl_upload to assert after a request before aborting.

Ports:
- clk, in, 1: system clock (clk_sys).
- reset, in, 1: asynchronous, active-high reset.
- save_req, in, 1: single-cycle request to start a dump (from OSD status bit edge).
- ioctl_upload_req, out, 1: one-cycle pulse asking hps_io to begin an upload.
- ioctl_upload, in, 1: high while the HPS upload is in progress.
- ioctl_rd, in, 1: single-cycle read strobe from hps_io.
- ioctl_addr, in, 25: byte offset of the current read, valid with ioctl_rd.
- ioctl_din, out, 8: byte returned to hps_io.
- ram_a, out, ADDR_W: dpram read address.
- ram_q, in, 8: dpram read data; 1-clock registered latency.
- busy, out, 1: high from request until done/abort; external mux gives ram_a priority while high.
- done, out, 1: one-cycle pulse on successful completion.
- err, out, 1: one-cycle pulse on timeout abort.

Behaviour:
- Reset values (async reset asserted): state IDLE; ioctl_upload_req=0, ioctl_din=8'h00, ram_a=0, busy=0, done=0, err=0, timeout counter=0, pipeline valids=0.
- State REQ:
  - Entered from IDLE on save_req; ioctl_upload_req=1 for exactly that one cycle.
  - busy=1 from the REQ cycle onward.
  - Next state WAIT.
- State WAIT:
  - The counter increments each clk.
  - Rising of ioctl_upload (sampled high) -> ACTIVE, counter cleared.
  - Counter == TIMEOUT-1 without ioctl_upload -> err pulse, IDLE, busy=0.
- State ACTIVE, read pipeline:
  - Cycle 0: ioctl_rd=1 -> ram_a <= (BASE + ioctl_addr[ADDR_W-1:0]) mod 2^ADDR_W; s1_oob <= (ioctl_addr >= SIZE).
  - Cycle 1: dpram registers the read.
  - Cycle 2: ioctl_din <= s2_oob ? 8'hFF : ram_q.
  - ioctl_din is valid 2 clocks after ioctl_rd and held until the next update.
  - Back-to-back ioctl_rd on consecutive clocks is fully pipelined, one byte per clock, in order.
  - The oob comparison uses all 25 address bits. Offsets >= SIZE never alias, even when the address wraps modulo 2^ADDR_W.
- Completion: ioctl_upload falling while ACTIVE -> in-flight pipeline stages still complete to ioctl_din. done pulses 2 clocks after the fall, then IDLE, busy=0.
- Ignored events:
  - save_req in any state other than IDLE.
  - ioctl_rd outside ACTIVE: no ram_a or ioctl_din change.
- Simultaneous events:
  - ioctl_rd on the same clock ioctl_upload falls: the read is still served.
  - ioctl_upload already high when REQ is entered: WAIT exits on the first clock.
- Reset mid-operation (any state): immediate return to reset values. No done or err pulse.
- ram_a holds its last value in IDLE.

Optional Feature:
- Macro PV1000_UPLOAD_CKSUM_EN.
- When defined:
  - Extra output cksum[7:0].
  - Cleared on entering REQ.
  - Each byte delivered to ioctl_din while ACTIVE (including 8'hFF fill) is added modulo 256 in the same clock.
  - cksum is stable from the done pulse until the next REQ.
- When undefined: the port is absent and no adder logic exists.

Test Plan:
- Dump basics: preload dpram[i]=i[7:0]; save_req; raise ioctl_upload 5 clks later; ioctl_rd at addr 0..255 every 3 clks; drop ioctl_upload.
  -> ioctl_upload_req is a single pulse.
  -> ioctl_din = addr[7:0] two clocks after each rd.
  -> done pulses once, busy falls.
- Pipelining/BASE: BASE=16'hFFFE, rd on consecutive clocks at addr 0,1,2,3 -> ioctl_din sequence dpram[FFFE],dpram[FFFF],dpram[0000],dpram[0001] on consecutive clocks.
- Out-of-range: SIZE=4096, rd addr 4095 then 4096 and 25'h10000 -> 4095 returns dpram data; the other two return 8'hFF.
- Timeout: TIMEOUT=100, save_req, never assert ioctl_upload -> err pulses on clk 100 after REQ; busy=0; a later save_req restarts normally.
- Ignore/reset: save_req during ACTIVE -> no second ioctl_upload_req. Assert reset mid-ACTIVE -> all outputs at reset values within the same clock, no done.
- PV1000_UPLOAD_CKSUM_EN: dpram[0..3]=8'h80,8'h80,8'h01,8'h02, upload 4 bytes -> cksum=8'h03 at done.

Source files
------------

// File: rtl/pv1000_ram_uploader.sv
// Streams the PV-1000 system dpram back to the HPS over the hps_io ioctl upload handshake.
// Define PV1000_UPLOAD_CKSUM_EN to add a modulo-256 byte checksum output (cksum).
module pv1000_ram_uploader #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned SIZE    = 65536,
   parameter int unsigned BASE    = 0,
   parameter int unsigned TIMEOUT = 16777215
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              save_req,
   output logic              ioctl_upload_req,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic [ADDR_W-1:0] ram_a,
   input  logic [7:0]        ram_q,
   output logic              busy,
   output logic              done,
`ifdef PV1000_UPLOAD_CKSUM_EN
   output logic              err,
   output logic [7:0]        cksum
`else
   output logic              err
`endif
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ACTIVE,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             done_next, err_next;
   logic             rd_go;
   logic             s1_v, s1_oob, s2_v, s2_oob;
   logic [7:0]       byte_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         done  <= done_next;
         err   <= err_next;
      end
   end

   // The counter runs from the REQ cycle, so err lands TIMEOUT clocks after REQ.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      done_next        = 1'b0;
      err_next         = 1'b0;
      ioctl_upload_req = (state == S_REQ);
      busy             = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            cnt_next = '0;
            if (save_req) state_next = S_REQ;
         end
         S_REQ: begin
            cnt_next   = cnt + 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (ioctl_upload) begin
               state_next = S_ACTIVE;
               cnt_next   = '0;
            end else if (32'(cnt) >= TIMEOUT - 1) begin
               state_next = S_IDLE;
               cnt_next   = '0;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         S_ACTIVE: if (!ioctl_upload) state_next = S_DRAIN;
         S_DRAIN:  state_next = S_FLUSH;
         S_FLUSH: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   assign rd_go    = ioctl_rd && (state == S_ACTIVE);
   assign byte_out = s2_oob ? 8'hFF : ram_q;

   // Two-stage valid pipeline matches the dpram's registered read; drains after upload falls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_a     <= '0;
         ioctl_din <= '0;
         s1_v      <= 1'b0;
         s1_oob    <= 1'b0;
         s2_v      <= 1'b0;
         s2_oob    <= 1'b0;
      end else begin
         s1_v <= rd_go;
         if (rd_go) begin
            ram_a  <= ADDR_W'(BASE) + ioctl_addr[ADDR_W-1:0];
            s1_oob <= 32'(ioctl_addr) >= SIZE;
         end
         s2_v   <= s1_v;
         s2_oob <= s1_oob;
         if (s2_v) ioctl_din <= byte_out;
      end
   end

`ifdef PV1000_UPLOAD_CKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cksum <= '0;
      end else if (state == S_IDLE && save_req) begin
         cksum <= '0;
      end else if (s2_v) begin
         cksum <= cksum + byte_out;
      end
   end
`endif

endmodule
